// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner selection for the shared tri-state system
// bus and the RAM behind it. Grants are registered and one-hot. There is always
// one dead cycle between two owners. An owner that reaches HOLD_MAX cycles
// while another master waits is warned through revoke and forced off the bus.
//
// Ports
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   req       per-master request; held high for the whole ownership
//   gnt       registered one-hot grant (or zero)
//   revoke    one-cycle warning: the owner's grant ends after this cycle
//   owner_id  index of the current (or most recent) owner
//   bus_idle  high when no grant is active
//
// Optional feature: SYSBUS_ARB_CPU_PRIORITY_EN
//   Master 0 always wins arbitration when it requests. It is exempt from the
//   hold limit. Masters 1..N_REQ-1 rotate among themselves.
//
// state | meaning
// IDLE  | no owner, no turnaround pending; arbitrate on req
// OWNED | one master holds gnt; hold_cnt counts owned cycles
// TURN  | single dead cycle after an owner leaves; arbitrate on req

module sysbus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int HOLD_MAX = 16,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] revoke,
    output logic [ID_W-1:0]  owner_id,
    output logic             bus_idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_n;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]   owner_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand;
    logic              win_found;
    logic              at_limit;
    logic              competitor;
    logic              hold_exempt;

    // Winner search: the first requester found upward from rr_ptr+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
`ifdef SYSBUS_ARB_CPU_PRIORITY_EN
            if (!win_found && req[cand] && (cand != '0)) begin
`else
            if (!win_found && req[cand]) begin
`endif
                win_found = 1'b1;
                win_id    = cand;
            end
        end
`ifdef SYSBUS_ARB_CPU_PRIORITY_EN
        // The CPU overrides the rotation whenever it asks.
        if (req[0]) begin
            win_found = 1'b1;
            win_id    = '0;
        end
`endif
    end

    assign at_limit   = (hold_cnt == CNT_W'(HOLD_MAX));
    // The owner's own bit is masked off; any other request counts as waiting.
    assign competitor = |(req & ~gnt);
`ifdef SYSBUS_ARB_CPU_PRIORITY_EN
    assign hold_exempt = (owner_id == '0);
`else
    assign hold_exempt = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        owner_n    = owner_id;
        hold_cnt_n = hold_cnt;
        rr_ptr_n   = rr_ptr;
        revoke     = '0;
        unique case (state)
            S_IDLE, S_TURN: begin
                hold_cnt_n = '0;
                gnt_n      = '0;
                state_n    = S_IDLE;
                if (win_found) begin
                    state_n    = S_OWNED;
                    gnt_n      = N_REQ'(1) << win_id;
                    owner_n    = win_id;
                    rr_ptr_n   = win_id;
                    hold_cnt_n = CNT_W'(1);
                end
            end
            S_OWNED: begin
                hold_cnt_n = at_limit ? hold_cnt : hold_cnt + CNT_W'(1);
                // A voluntary release wins over a forced one, so revoke stays low.
                if (!req[owner_id]) begin
                    state_n    = S_TURN;
                    gnt_n      = '0;
                    hold_cnt_n = '0;
                end else if (at_limit && competitor && !hold_exempt) begin
                    revoke[owner_id] = 1'b1;
                    state_n          = S_TURN;
                    gnt_n            = '0;
                    hold_cnt_n       = '0;
                end
            end
            default: begin
                state_n    = S_IDLE;
                gnt_n      = '0;
                hold_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            owner_id <= '0;
            hold_cnt <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner_id <= owner_n;
            hold_cnt <= hold_cnt_n;
            rr_ptr   <= rr_ptr_n;
        end
    end

    assign bus_idle = (gnt == '0);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter (N_REQ = 3, HOLD_MAX = 4). It runs directed
// scenarios and then a randomized request pattern. Every cycle is compared
// against an ownership-level reference model.

module tb_sysbus_arbiter;

    localparam int N = 3;
    localparam int HOLD_MAX = 4;
    localparam int IDW = $clog2(N);
`ifdef SYSBUS_ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   revoke;
    logic [IDW-1:0] owner_id;
    logic           bus_idle;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, for how long, and who won last.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;
    int m_oid   = 0;

    sysbus_arbiter #(.N_REQ(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .revoke   (revoke),
        .owner_id (owner_id),
        .bus_idle (bus_idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int w;
        w = -1;
        if (PRIO && r[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (w < 0 && r[i] && !(PRIO && i == 0)) w = i;
        end
        return w;
    endfunction

    // One clock cycle: compare against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        int w;
        @(negedge clock);
        eg = '0;
        er = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_owner >= 0 && req[m_owner] && m_held >= HOLD_MAX &&
            ((req & ~eg) != '0) && !(PRIO && m_owner == 0))
            er[m_owner] = 1'b1;
        chk("model_gnt", gnt, eg);
        chk("model_revoke", revoke, er);
        chk("model_owner_id", owner_id, m_oid);
        chk("model_bus_idle", bus_idle, (eg == '0));
        @(posedge clock);
        if (reset) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_oid = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner] || er != '0) m_owner = -1;
            else m_held++;
        end else begin
            w = pick(req);
            if (w >= 0) begin
                m_owner = w; m_oid = w; m_last = w; m_held = 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r);
        req = r;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rq;
        reset = 1'b1;
        req   = '0;
        @(posedge clock);
        #1;
        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_revoke", revoke, 0);
        chk("rst_owner_id", owner_id, 0);
        chk("rst_bus_idle", bus_idle, 1);

`ifndef SYSBUS_ARB_CPU_PRIORITY_EN
        // Single request: one-cycle latency, then release with a turnaround.
        drive(3'b001); chk("s1_latency", gnt, 0); tick();
        drive(3'b001); chk("s1_gnt", gnt, 3'b001); chk("s1_owner", owner_id, 0);
        chk("s1_busy", bus_idle, 0); tick();
        repeat (3) begin drive(3'b001); tick(); end
        drive(3'b000); chk("s1_hold_until_edge", gnt, 3'b001); tick();
        drive(3'b000); chk("s1_turn", gnt, 0); tick();
        drive(3'b000); chk("s1_idle", gnt, 0); tick();

        // Two requesters together after reset; master 0 releases at the hold limit.
        do_reset();
        drive(3'b011); chk("s2_latency", gnt, 0); tick();
        drive(3'b011); chk("s2_first", gnt, 3'b001); tick();
        drive(3'b011); tick();
        drive(3'b011); tick();
        drive(3'b010); chk("s2_rel_gnt", gnt, 3'b001); chk("s2_rel_norevoke", revoke, 0); tick();
        drive(3'b010); chk("s2_dead", gnt, 0); tick();
        drive(3'b010); chk("s2_next", gnt, 3'b010); chk("s2_owner", owner_id, 1); tick();

        // Hold limit: competitor arrives in owned cycle 2, revoke in owned cycle 4.
        do_reset();
        drive(3'b001); tick();
        drive(3'b001); chk("s3_own", gnt, 3'b001); tick();
        drive(3'b011); chk("s3_c2_norevoke", revoke, 0); tick();
        drive(3'b011); chk("s3_c3_norevoke", revoke, 0); tick();
        drive(3'b011); chk("s3_revoke", revoke, 3'b001); chk("s3_c4_gnt", gnt, 3'b001); tick();
        drive(3'b011); chk("s3_turn", gnt, 0); chk("s3_turn_revoke", revoke, 0); tick();
        drive(3'b011); chk("s3_switch", gnt, 3'b010); chk("s3_owner", owner_id, 1); tick();

        // Reset in the middle of master 1's ownership.
        reset = 1'b1; drive(3'b011); tick(); reset = 1'b0;
        chk("s5_gnt", gnt, 0); chk("s5_owner", owner_id, 0); chk("s5_idle", bus_idle, 1);
        drive(3'b011); tick();
        chk("s5_regrant", gnt, 3'b001);
        drive(3'b000); tick(); tick();

        // Lone master for 40 cycles: never revoked.
        do_reset();
        drive(3'b001); tick();
        for (int c = 0; c < 40; c++) begin
            drive(3'b001);
            chk("s4_keep_gnt", gnt, 3'b001);
            chk("s4_no_revoke", revoke, 0);
            tick();
        end
        drive(3'b000); tick(); tick();
`else
        // CPU priority: master 1 owns, master 2 waits, CPU arrives; CPU wins after TURN.
        do_reset();
        drive(3'b010); tick();
        drive(3'b110); chk("p_m1_owns", gnt, 3'b010); tick();
        drive(3'b111); tick();
        drive(3'b101); tick();
        drive(3'b101); chk("p_turn", gnt, 0); tick();
        for (int c = 0; c < 10; c++) begin
            drive(3'b101);
            chk("p_cpu_gnt", gnt, 3'b001);
            chk("p_cpu_no_revoke", revoke, 0);
            tick();
        end
        drive(3'b000); tick(); tick();
`endif

        // Randomized traffic against the model.
        do_reset();
        rq = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 5) == 0) rq[i] = 1'b0;
                end else if (!rq[i]) begin
                    if ($urandom_range(0, 3) == 0) rq[i] = 1'b1;
                end else if ($urandom_range(0, 19) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            drive(rq);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
